// File: rtl/pixel_layer_arbiter_pkg.sv
// Shared types and constants for the VGA layer compositor and the draw_* modules.
package pixel_layer_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLASH  = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_WHITE = 3'b111;
    localparam logic [2:0] COLOR_RED   = 3'b100;

    // Visible area, shared with the timing generator and the draw layers
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_V_VISIBLE = 480;

endpackage

// File: rtl/pixel_layer_arbiter_mux.sv
// Combinational priority select over the draw layers; layer 0 may be masked
// (flash off) or recoloured (frozen border).
module layer_priority_mux
    import pixel_layer_arbiter_pkg::*;
#(
    parameter int N_LAYERS = 4
) (
    input  logic [N_LAYERS-1:0]   layer_active,
    input  logic [3*N_LAYERS-1:0] layer_rgb,
    input  logic                  mask_layer0,
    input  logic                  override_en,
    input  logic [2:0]            override_rgb,
    output logic [2:0]            rgb
);

    // Walk from lowest to highest priority so the lowest active index wins
    always_comb begin
        rgb = COLOR_BLACK;
        for (int i = N_LAYERS - 1; i >= 1; i--) begin
            if (layer_active[i]) begin
                rgb = layer_rgb[3*i +: 3];
            end
        end
        if (layer_active[0] && !mask_layer0) begin
            rgb = override_en ? override_rgb : layer_rgb[2:0];
        end
    end

endmodule

// File: rtl/pixel_layer_arbiter.sv
// Pixel compositor: layer priority, blanking, frame tick and game-over flash sequencing.
module pixel_layer_arbiter
    import pixel_layer_arbiter_pkg::*;
#(
    parameter int         BIT           = 10,
    parameter int         N_LAYERS      = 4,
    parameter int         H_VISIBLE     = VGA_H_VISIBLE,
    parameter int         V_VISIBLE     = VGA_V_VISIBLE,
    parameter int         FLASH_FRAMES  = 16,
    parameter int         FLASH_TOGGLES = 6,
    parameter logic [2:0] FROZEN_RGB    = COLOR_RED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIT-1:0]        x_pos,
    input  logic [BIT-1:0]        y_pos,
    input  logic [N_LAYERS-1:0]   layer_active,
    input  logic [3*N_LAYERS-1:0] layer_rgb,
    input  logic                  game_over,
    output logic [2:0]            rgb_out,
    output logic                  frame_tick,
    output logic                  flash_on
);

    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int TW = $clog2(FLASH_TOGGLES + 1);

    state_t        state_reg, state_next;
    logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
    logic [TW-1:0] toggle_cnt_reg, toggle_cnt_next;
    logic          flash_next;
    logic          match, match_reg;
    logic          go_reg, go_prev_reg, go_rise;
    logic          visible;
    logic [2:0]    mux_rgb;

    assign match   = (x_pos == '0) && (y_pos == BIT'(V_VISIBLE));
    assign visible = (x_pos < BIT'(H_VISIBLE)) && (y_pos < BIT'(V_VISIBLE));
    assign go_rise = go_reg && !go_prev_reg;

    layer_priority_mux #(
        .N_LAYERS (N_LAYERS)
    ) u_mux (
        .layer_active (layer_active),
        .layer_rgb    (layer_rgb),
        .mask_layer0  ((state_reg == ST_FLASH) && !flash_on),
        .override_en  (state_reg == ST_FROZEN),
        .override_rgb (FROZEN_RGB),
        .rgb          (mux_rgb)
    );

    always_comb begin
        state_next      = state_reg;
        frame_cnt_next  = frame_cnt_reg;
        toggle_cnt_next = toggle_cnt_reg;
        flash_next      = flash_on;
        // A dropped game_over overrides everything, including a final toggle
        if (!game_over) begin
            state_next      = ST_RUN;
            frame_cnt_next  = '0;
            toggle_cnt_next = '0;
            flash_next      = 1'b1;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    frame_cnt_next  = '0;
                    toggle_cnt_next = '0;
                    flash_next      = 1'b1;
                    if (go_rise) begin
                        state_next = ST_FLASH;
                    end
                end
                ST_FLASH: begin
                    if (frame_tick) begin
                        if (frame_cnt_reg == FW'(FLASH_FRAMES - 1)) begin
                            frame_cnt_next  = '0;
                            toggle_cnt_next = toggle_cnt_reg + 1'b1;
                            flash_next      = !flash_on;
                            if (toggle_cnt_reg == TW'(FLASH_TOGGLES - 1)) begin
                                state_next = ST_FROZEN;
                                flash_next = 1'b1;
                            end
                        end else begin
                            frame_cnt_next = frame_cnt_reg + 1'b1;
                        end
                    end
                end
                ST_FROZEN: begin
                    flash_next = 1'b1;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            frame_cnt_reg  <= '0;
            toggle_cnt_reg <= '0;
            flash_on       <= 1'b1;
            rgb_out        <= COLOR_BLACK;
            frame_tick     <= 1'b0;
            match_reg      <= 1'b0;
            go_reg         <= 1'b0;
            go_prev_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_cnt_reg  <= frame_cnt_next;
            toggle_cnt_reg <= toggle_cnt_next;
            flash_on       <= flash_next;
            rgb_out        <= visible ? mux_rgb : COLOR_BLACK;
            frame_tick     <= match && !match_reg;
            match_reg      <= match;
            go_reg         <= game_over;
            go_prev_reg    <= go_reg;
        end
    end

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Randomized bench for pixel_layer_arbiter against a behavioural frame/flash model.
module tb_pixel_layer_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x_pos, y_pos;
    logic [3:0]  layer_active;
    logic [11:0] layer_rgb;
    logic        game_over;
    logic [2:0]  rgb_out;
    logic        frame_tick, flash_on;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=RUN 1=FLASH 2=FROZEN
    int m_mode, m_frames, m_toggles;
    bit m_flash, m_tick, m_prev_match, m_go1, m_go2;

    pixel_layer_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .layer_active (layer_active),
        .layer_rgb    (layer_rgb),
        .game_over    (game_over),
        .rgb_out      (rgb_out),
        .frame_tick   (frame_tick),
        .flash_on     (flash_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_frames = 0; m_toggles = 0;
        m_flash = 1; m_tick = 0; m_prev_match = 0; m_go1 = 0; m_go2 = 0;
    endtask

    function automatic int model_rgb(input int x, input int y, input logic [3:0] act,
                                     input logic [11:0] rgb);
        logic [11:0] r;
        r = rgb;
        if (x >= 640 || y >= 480) return 0;
        for (int i = 0; i < 4; i++) begin
            if (act[i]) begin
                if (i == 0 && m_mode == 1 && !m_flash) continue;
                if (i == 0 && m_mode == 2) return 4;
                return int'(r[3*i +: 3]);
            end
        end
        return 0;
    endfunction

    // One pixel clock: drive, clock, advance model, compare
    task automatic step(input string tag, input int x, input int y, input logic [3:0] act,
                        input logic [11:0] rgb, input bit go);
        int  e_rgb;
        bit  match, rise;
        x_pos = 10'(x); y_pos = 10'(y); layer_active = act; layer_rgb = rgb; game_over = go;
        e_rgb = model_rgb(x, y, act, rgb);
        match = (x == 0 && y == 480);
        rise  = m_go1 && !m_go2;
        @(posedge clk);
        if (!go) begin
            m_mode = 0; m_flash = 1; m_frames = 0; m_toggles = 0;
        end else if (m_mode == 0) begin
            if (rise) begin
                m_mode = 1; m_frames = 0; m_toggles = 0; m_flash = 1;
            end
        end else if (m_mode == 1 && m_tick) begin
            m_frames++;
            if (m_frames == 16) begin
                m_frames = 0;
                m_flash  = !m_flash;
                m_toggles++;
                if (m_toggles == 6) begin
                    m_mode = 2; m_flash = 1;
                end
            end
        end
        m_tick = match && !m_prev_match;
        m_prev_match = match;
        m_go2 = m_go1;
        m_go1 = go;
        #1;
        $display("%s x=%0d y=%0d act=%b go=%b -> rgb=%b tick=%b flash=%b mode=%0d",
                 tag, x, y, act, go, rgb_out, frame_tick, flash_on, m_mode);
        check({tag, "_rgb"},   int'(rgb_out),    e_rgb);
        check({tag, "_tick"},  int'(frame_tick), int'(m_tick));
        check({tag, "_flash"}, int'(flash_on),   int'(m_flash));
    endtask

    task automatic frame(input bit go);
        for (int k = 0; k < 3; k++) begin
            step("pix", $urandom_range(0, 700), $urandom_range(0, 500),
                 4'($urandom), 12'($urandom), go);
        end
        step("vsync", 0, 480, 4'($urandom), 12'($urandom), go);
    endtask

    initial begin
        bit seen_off;
        reset = 1'b1;
        x_pos = '0; y_pos = '0; layer_active = '0; layer_rgb = '0; game_over = 1'b0;
        model_reset();
        #2;
        check("reset_rgb",   int'(rgb_out),    0);
        check("reset_tick",  int'(frame_tick), 0);
        check("reset_flash", int'(flash_on),   1);
        @(negedge clk);
        reset = 1'b0;

        // Priority and blanking
        step("pri_l0", 5, 5, 4'b0101, 12'b000_010_000_111, 1'b0);
        check("pri_l0_exact", int'(rgb_out), 3'b111);
        step("pri_l2", 5, 5, 4'b0100, 12'b000_010_000_111, 1'b0);
        check("pri_l2_exact", int'(rgb_out), 3'b010);
        step("pri_none", 5, 5, 4'b0000, 12'b111_111_111_111, 1'b0);
        step("blank_x", 640, 10, 4'b0001, 12'b000_000_000_111, 1'b0);
        step("blank_y", 10, 480, 4'b0001, 12'b000_000_000_111, 1'b0);

        // frame_tick on the first cycle of a held match only
        step("tick_pre", 3, 3, 4'b0000, 12'h0, 1'b0);
        step("tick_m1", 0, 480, 4'b0000, 12'h0, 1'b0);
        check("tick_first", int'(frame_tick), 1);
        step("tick_m2", 0, 480, 4'b0000, 12'h0, 1'b0);
        step("tick_m3", 0, 480, 4'b0000, 12'h0, 1'b0);
        step("tick_479", 0, 479, 4'b0000, 12'h0, 1'b0);
        step("tick_x1", 1, 480, 4'b0000, 12'h0, 1'b0);

        // Random RUN traffic
        for (int n = 0; n < 40; n++) begin
            step("run", $urandom_range(0, 700), $urandom_range(0, 500),
                 4'($urandom), 12'($urandom), 1'b0);
        end

        // Full flash sequence to FROZEN
        seen_off = 0;
        for (int f = 0; f < 120 && m_mode != 2; f++) begin
            frame(1'b1);
            if (m_mode == 1 && !m_flash && !seen_off) begin
                seen_off = 1;
                step("flash_off", 100, 100, 4'b0011, 12'b000_000_001_111, 1'b1);
                check("flash_off_exact", int'(rgb_out), 3'b001);
            end
        end
        step("frozen_pre", 20, 20, 4'b0001, 12'b000_000_000_111, 1'b1);
        step("frozen", 20, 20, 4'b0001, 12'b000_000_000_111, 1'b1);
        check("frozen_border", int'(rgb_out), 3'b100);
        check("frozen_flash", int'(flash_on), 1);

        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("areset_rgb",   int'(rgb_out),    0);
        check("areset_tick",  int'(frame_tick), 0);
        check("areset_flash", int'(flash_on),   1);
        game_over = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Abort mid-FLASH while the border is hidden
        for (int f = 0; f < 40 && !(m_mode == 1 && !m_flash); f++) begin
            frame(1'b1);
        end
        step("abort_drop", 10, 10, 4'b0001, 12'b000_000_000_111, 1'b0);
        check("abort_flash", int'(flash_on), 1);
        step("abort_run", 10, 10, 4'b0001, 12'b000_000_000_111, 1'b0);
        check("abort_border", int'(rgb_out), 3'b111);

        // Mixed random traffic with occasional game_over drops
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                step("mix_vs", 0, 480, 4'($urandom), 12'($urandom), $urandom_range(0, 15) != 0);
            end else begin
                step("mix", $urandom_range(0, 700), $urandom_range(0, 500),
                     4'($urandom), 12'($urandom), $urandom_range(0, 15) != 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
